// File: rtl/batalha_naval_attack_controller.sv
// Naval-battle game sequencer: runs IDLE/PREP/COUNT/ATTACK/END, counts the
// latched ship map, resolves attacks and tracks shots / remaining ship cells.
module batalha_naval_attack_controller #(
  parameter int MAX_SHOTS = 15,
  parameter int SHOT_W    = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              prep_done,
  input  logic              fire,
  input  logic [2:0]        x_coord,
  input  logic [2:0]        y_coord,
  input  logic [34:0]       map,
  output logic [1:0]        game_state_code,
  output logic              attack_valid,
  output logic              hit,
  output logic              miss,
  output logic              repeat_shot,
  output logic              invalid_shot,
  output logic [34:0]       hits_map,
  output logic [SHOT_W-1:0] shots_left,
  output logic [5:0]        ships_left,
  output logic              win,
  output logic              lose
);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_COUNT, S_ATTACK, S_END} state_t;

  localparam logic [5:0] IDX_LAST = 6'd34;

  state_t      r_state, w_next;
  logic [34:0] r_map_q;
  logic [5:0]  r_idx;

  logic        w_coord_ok, w_repeat, w_ship, w_shot, w_count_bit;
  logic        w_win_shot, w_lose_shot, w_count_zero, w_enter_prep;
  logic [5:0]  w_cell_idx;
  logic [34:0] w_cell;

  // Decode the attacked cell and classify the shot; termination is known
  // combinationally so the FSM can leave ATTACK on the same edge.
  always_comb begin
    w_coord_ok   = (x_coord != 3'd7) && (y_coord <= 3'd4);
    w_cell_idx   = (6'd4 - {3'b000, y_coord}) * 6'd7 + {3'b000, x_coord};
    w_cell       = w_coord_ok ? (35'd1 << w_cell_idx) : 35'd0;
    w_repeat     = |(hits_map & w_cell);
    w_ship       = |(r_map_q & w_cell);
    w_shot       = (r_state == S_ATTACK) && fire && w_coord_ok && !w_repeat;
    w_win_shot   = w_shot && w_ship && (ships_left == 6'd1);
    w_lose_shot  = w_shot && !w_win_shot && (shots_left == SHOT_W'(1));
    w_count_bit  = r_map_q[r_idx];
    w_count_zero = (ships_left == 6'd0) && !w_count_bit;
    w_enter_prep = start && ((r_state == S_IDLE) || (r_state == S_END));
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic and state code decode.
  always_comb begin
    w_next          = r_state;
    game_state_code = 2'b00;
    case (r_state)
      S_IDLE:   if (start) w_next = S_PREP;
      S_PREP: begin
        game_state_code = 2'b01;
        if (prep_done) w_next = S_COUNT;
      end
      S_COUNT: begin
        game_state_code = 2'b10;
        if (r_idx == IDX_LAST) w_next = w_count_zero ? S_END : S_ATTACK;
      end
      S_ATTACK: begin
        game_state_code = 2'b10;
        if (w_win_shot || w_lose_shot) w_next = S_END;
      end
      S_END: begin
        game_state_code = 2'b11;
        if (start) w_next = S_PREP;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  // Datapath: map latch, ship count, attack resolution and result pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_map_q      <= '0;
      r_idx        <= '0;
      hits_map     <= '0;
      shots_left   <= '0;
      ships_left   <= '0;
      win          <= 1'b0;
      lose         <= 1'b0;
      attack_valid <= 1'b0;
      hit          <= 1'b0;
      miss         <= 1'b0;
      repeat_shot  <= 1'b0;
      invalid_shot <= 1'b0;
    end else begin
      attack_valid <= 1'b0;
      hit          <= 1'b0;
      miss         <= 1'b0;
      repeat_shot  <= 1'b0;
      invalid_shot <= 1'b0;
      if (w_enter_prep) begin
        hits_map   <= '0;
        ships_left <= '0;
        win        <= 1'b0;
        lose       <= 1'b0;
        shots_left <= SHOT_W'(MAX_SHOTS);
        r_idx      <= '0;
      end
      if (r_state == S_PREP && prep_done) begin
        r_map_q <= map;
        r_idx   <= '0;
      end
      if (r_state == S_COUNT) begin
        ships_left <= ships_left + {5'b00000, w_count_bit};
        r_idx      <= r_idx + 6'd1;
        if (r_idx == IDX_LAST && w_count_zero) win <= 1'b1;
      end
      if (r_state == S_ATTACK && fire) begin
        if (!w_coord_ok)    invalid_shot <= 1'b1;
        else if (w_repeat)  repeat_shot  <= 1'b1;
        else begin
          hits_map     <= hits_map | w_cell;
          shots_left   <= shots_left - SHOT_W'(1);
          attack_valid <= 1'b1;
          hit          <= w_ship;
          miss         <= !w_ship;
          if (w_ship) ships_left <= ships_left - 6'd1;
          if (w_win_shot)  win  <= 1'b1;
          if (w_lose_shot) lose <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_batalha_naval_attack_controller.sv
// Directed bench: two controllers (15 and 2 shots) share one stimulus stream.
module tb_batalha_naval_attack_controller;

  logic clk = 1'b0;
  logic rst_n, start, prep_done, fire;
  logic [2:0]  x, y;
  logic [34:0] map;

  logic [1:0]  a_st, b_st;
  logic        a_av, a_hit, a_miss, a_rep, a_inv, a_win, a_lose;
  logic        b_av, b_hit, b_miss, b_rep, b_inv, b_win, b_lose;
  logic [34:0] a_hm, b_hm;
  logic [5:0]  a_shots, b_shots, a_ships, b_ships;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  batalha_naval_attack_controller #(.MAX_SHOTS(15), .SHOT_W(6)) u_a (
    .clk(clk), .reset(rst_n), .start(start), .prep_done(prep_done), .fire(fire),
    .x_coord(x), .y_coord(y), .map(map), .game_state_code(a_st),
    .attack_valid(a_av), .hit(a_hit), .miss(a_miss), .repeat_shot(a_rep),
    .invalid_shot(a_inv), .hits_map(a_hm), .shots_left(a_shots),
    .ships_left(a_ships), .win(a_win), .lose(a_lose));

  batalha_naval_attack_controller #(.MAX_SHOTS(2), .SHOT_W(6)) u_b (
    .clk(clk), .reset(rst_n), .start(start), .prep_done(prep_done), .fire(fire),
    .x_coord(x), .y_coord(y), .map(map), .game_state_code(b_st),
    .attack_valid(b_av), .hit(b_hit), .miss(b_miss), .repeat_shot(b_rep),
    .invalid_shot(b_inv), .hits_map(b_hm), .shots_left(b_shots),
    .ships_left(b_ships), .win(b_win), .lose(b_lose));

  // {attack_valid, hit, miss, repeat_shot, invalid_shot}
  localparam logic [4:0] P_NONE = 5'b00000, P_HIT = 5'b11000, P_MISS = 5'b10100,
                         P_REP  = 5'b00010, P_INV = 5'b00001;

  typedef struct {
    logic [2:0] x, y;
    logic [4:0] a_p; logic [5:0] a_shots, a_ships; logic [1:0] a_st; logic a_w, a_l;
    logic [4:0] b_p; logic [5:0] b_shots, b_ships; logic [1:0] b_st; logic b_w, b_l;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_prep(input logic [34:0] m);
    map = m; prep_done = 1'b1; tick(); prep_done = 1'b0;
    map = '1;  // later map changes must not matter
  endtask

  task automatic shoot(input logic [2:0] xx, input logic [2:0] yy);
    x = xx; y = yy; fire = 1'b1; tick(); fire = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start = 1'($urandom); prep_done = 1'($urandom); fire = 1'($urandom);
      x = 3'($urandom); y = 3'($urandom); map = 35'({$urandom, $urandom});
      tick();
    end
    start = 0; prep_done = 0; fire = 0; x = 0; y = 0; map = '0;
    rst_n = 1'b1;
  endtask

  function automatic logic [34:0] bit35(input int i);
    return 35'd1 << i;
  endfunction

  initial begin
    rst_n = 1'b0; start = 0; prep_done = 0; fire = 0; x = 0; y = 0; map = '0;

    // reset state
    do_reset();
    chk("reset_a", {a_st, a_av, a_hit, a_miss, a_rep, a_inv, a_hm, a_shots, a_ships, a_win, a_lose}, 64'd0);
    chk("reset_b", {b_st, b_av, b_hit, b_miss, b_rep, b_inv, b_hm, b_shots, b_ships, b_win, b_lose}, 64'd0);

    // count a map with cells {34,20,0}
    pulse_start();
    chk("prep_state", a_st, 2'b01);
    chk("prep_shots_a", a_shots, 6'd15);
    chk("prep_shots_b", b_shots, 6'd2);
    shoot(3'd0, 3'd0);  // fire outside ATTACK is ignored
    chk("prep_fire_ignored", {a_av, a_inv, a_rep, a_hm}, 64'd0);
    pulse_prep(bit35(34) | bit35(20) | bit35(0));
    begin
      int bad = 0;
      for (int i = 0; i < 34; i++) begin
        if (a_st != 2'b10) bad++;
        tick();
      end
      chk("count_state_34cyc", bad, 0);
      chk("count_ships_34cyc", a_ships, 6'd2);
      chk("count_state_35th", a_st, 2'b10);
      tick();
    end
    chk("count_ships_a", a_ships, 6'd3);
    chk("count_shots_a", a_shots, 6'd15);
    chk("count_ships_b", b_ships, 6'd3);
    chk("attack_state", a_st, 2'b10);
    pulse_start();
    chk("start_ignored_attack", {a_st, a_shots}, {2'b10, 6'd15});

    // empty map wins right after COUNT
    do_reset();
    pulse_start();
    pulse_prep('0);
    for (int i = 0; i < 34; i++) tick();
    chk("zero_map_still_count", a_st, 2'b10);
    tick();
    chk("zero_map_end_a", {a_st, a_win, a_lose}, {2'b11, 1'b1, 1'b0});
    chk("zero_map_end_b", {b_st, b_win, b_lose}, {2'b11, 1'b1, 1'b0});

    // main game: ships at cells {28,20,0} = (0,0),(6,2),(0,4)
    do_reset();
    pulse_start();
    pulse_prep(bit35(28) | bit35(20) | bit35(0));
    for (int i = 0; i < 35; i++) tick();
    chk("game_ships", a_ships, 6'd3);

    tbl[0] = '{3'd0, 3'd0, P_HIT,  6'd14, 6'd2, 2'b10, 0, 0, P_HIT,  6'd1, 6'd2, 2'b10, 0, 0};
    tbl[1] = '{3'd1, 3'd0, P_MISS, 6'd13, 6'd2, 2'b10, 0, 0, P_MISS, 6'd0, 6'd2, 2'b11, 0, 1};
    tbl[2] = '{3'd0, 3'd0, P_REP,  6'd13, 6'd2, 2'b10, 0, 0, P_NONE, 6'd0, 6'd2, 2'b11, 0, 1};
    tbl[3] = '{3'd7, 3'd2, P_INV,  6'd13, 6'd2, 2'b10, 0, 0, P_NONE, 6'd0, 6'd2, 2'b11, 0, 1};
    tbl[4] = '{3'd3, 3'd5, P_INV,  6'd13, 6'd2, 2'b10, 0, 0, P_NONE, 6'd0, 6'd2, 2'b11, 0, 1};
    tbl[5] = '{3'd6, 3'd2, P_HIT,  6'd12, 6'd1, 2'b10, 0, 0, P_NONE, 6'd0, 6'd2, 2'b11, 0, 1};
    tbl[6] = '{3'd0, 3'd4, P_HIT,  6'd11, 6'd0, 2'b11, 1, 0, P_NONE, 6'd0, 6'd2, 2'b11, 0, 1};

    for (int i = 0; i < 7; i++) begin
      shoot(tbl[i].x, tbl[i].y);
      chk($sformatf("v%0d_a_flags", i), {a_st, a_av, a_hit, a_miss, a_rep, a_inv, a_win, a_lose},
          {tbl[i].a_st, tbl[i].a_p, tbl[i].a_w, tbl[i].a_l});
      chk($sformatf("v%0d_a_cnt", i), {a_shots, a_ships}, {tbl[i].a_shots, tbl[i].a_ships});
      chk($sformatf("v%0d_b_flags", i), {b_st, b_av, b_hit, b_miss, b_rep, b_inv, b_win, b_lose},
          {tbl[i].b_st, tbl[i].b_p, tbl[i].b_w, tbl[i].b_l});
      chk($sformatf("v%0d_b_cnt", i), {b_shots, b_ships}, {tbl[i].b_shots, tbl[i].b_ships});
      if (i == 0) chk("v0_hits_map", a_hm, bit35(28));
    end
    chk("hits_map_a", a_hm, bit35(28) | bit35(29) | bit35(20) | bit35(0));
    tick();
    chk("end_hold_a", {a_st, a_win, a_av, a_hit, a_shots}, {2'b11, 1'b1, 1'b0, 1'b0, 6'd11});

    // restart reloads; then B loses on two misses
    pulse_start();
    chk("restart_a", {a_st, a_hm, a_shots, a_ships, a_win, a_lose}, {2'b01, 35'd0, 6'd15, 6'd0, 1'b0, 1'b0});
    chk("restart_b", {b_st, b_shots, b_lose}, {2'b01, 6'd2, 1'b0});
    pulse_prep(bit35(28));
    for (int i = 0; i < 35; i++) tick();
    shoot(3'd1, 3'd0);
    shoot(3'd2, 3'd0);
    chk("lose_b", {b_st, b_win, b_lose, b_shots, b_miss}, {2'b11, 1'b0, 1'b1, 6'd0, 1'b1});
    chk("lose_a_running", {a_st, a_shots}, {2'b10, 6'd13});

    // B wins on its final shot; A ignores start/prep_done while attacking
    pulse_start();
    chk("start_b_prep", b_st, 2'b01);
    chk("start_a_ignored", a_st, 2'b10);
    pulse_prep(bit35(28) | bit35(29));
    for (int i = 0; i < 35; i++) tick();
    chk("b_ships2", b_ships, 6'd2);
    shoot(3'd0, 3'd0);
    chk("a_win_hit", {a_st, a_win, a_hit, a_ships}, {2'b11, 1'b1, 1'b1, 6'd0});
    shoot(3'd1, 3'd0);
    chk("final_shot_win_b", {b_st, b_win, b_lose, b_hit, b_shots, b_ships},
        {2'b11, 1'b1, 1'b0, 1'b1, 6'd0, 6'd0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
